// File: rtl/alu_operand_regfile_pkg.sv
// rtl/alu_operand_regfile_pkg.sv - shared widths, register count and zero-register index
// Shared with the ALU and memory blocks so that all three agree on operand widths.
package alu_operand_regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int REG_COUNT  = 32;   // must equal 2**ADDR_WIDTH, so no address is out of range
  localparam int ZERO_REG   = 0;    // hard-wired zero register

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  function automatic logic addr_is_zero(input addr_t a);
    return a == addr_t'(ZERO_REG);
  endfunction

endpackage

// File: rtl/alu_operand_regfile_if.sv
// rtl/alu_operand_regfile_if.sv - operand register file access bundle
// master: the sequencer / ALU side (drives strobes, addresses, write-back data)
// slave : the register file (returns registered operands and op_valid)
//   read, write          strobes sampled on the rising clock
//   addr_r1, addr_r2     read addresses (ALU OP1 / OP2)
//   addr_w, data_w       write-back address and data
//   data_r1, data_r2     registered operands
//   op_valid             high the cycle after a read was sampled
interface alu_operand_regfile_if;
  import alu_operand_regfile_pkg::*;

  logic  read;
  logic  write;
  addr_t addr_r1;
  addr_t addr_r2;
  addr_t addr_w;
  data_t data_w;
  data_t data_r1;
  data_t data_r2;
  logic  op_valid;

  modport master (
    output read, write, addr_r1, addr_r2, addr_w, data_w,
    input  data_r1, data_r2, op_valid
  );

  modport slave (
    input  read, write, addr_r1, addr_r2, addr_w, data_w,
    output data_r1, data_r2, op_valid
  );

endinterface

// File: rtl/reg_ld_async.sv
// rtl/reg_ld_async.sv - load-enabled register with asynchronous active-high clear
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high clear of q
//   ld   load enable; q takes d on the next rising clk when high, otherwise holds
//   d    load data
//   q    registered value
module reg_ld_async
  import alu_operand_regfile_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] val_d;
  logic [WIDTH-1:0] val_q;

  always_comb begin
    val_d = val_q;
    if (ld) begin
      val_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/alu_operand_regfile.sv
// rtl/alu_operand_regfile.sv - 32x32 operand register file, two registered read ports, one write port
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; clears every register, both read outputs and op_valid
//   rf   slave side of alu_operand_regfile_if (strobes, addresses, write data, operands, op_valid)
// A read at the address being written in the same cycle returns the incoming write data,
// so an ALU result written back can be consumed as an operand without a stall.
module alu_operand_regfile
  import alu_operand_regfile_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  alu_operand_regfile_if.slave   rf
);

  data_t                regs [REG_COUNT];
  logic [REG_COUNT-1:1] wr_en;
  data_t                rd1_d;
  data_t                rd2_d;
  logic                 op_valid_d;
  logic                 op_valid_q;

  // Register 0 has no storage; it is a constant zero.
  assign regs[ZERO_REG] = '0;

  // Write-enable decoder; entry 0 is absent so writes to r0 vanish.
  always_comb begin
    wr_en = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (rf.write && (rf.addr_w == addr_t'(i))) begin
        wr_en[i] = 1'b1;
      end
    end
  end

  for (genvar g = 1; g < REG_COUNT; g++) begin : g_regs
    reg_ld_async #(.WIDTH(DATA_WIDTH)) u_reg (
      .clk (clk),
      .rst (rst),
      .ld  (wr_en[g]),
      .d   (rf.data_w),
      .q   (regs[g])
    );
  end

  // Read muxes with write-to-read bypass; zero address wins over bypass.
  always_comb begin
    rd1_d = regs[rf.addr_r1];
    if (addr_is_zero(rf.addr_r1)) begin
      rd1_d = '0;
    end else if (rf.write && (rf.addr_w == rf.addr_r1)) begin
      rd1_d = rf.data_w;
    end
  end

  always_comb begin
    rd2_d = regs[rf.addr_r2];
    if (addr_is_zero(rf.addr_r2)) begin
      rd2_d = '0;
    end else if (rf.write && (rf.addr_w == rf.addr_r2)) begin
      rd2_d = rf.data_w;
    end
  end

  // Output registers only load on a read, so operands hold while read is low.
  reg_ld_async #(.WIDTH(DATA_WIDTH)) u_rd1 (
    .clk (clk),
    .rst (rst),
    .ld  (rf.read),
    .d   (rd1_d),
    .q   (rf.data_r1)
  );

  reg_ld_async #(.WIDTH(DATA_WIDTH)) u_rd2 (
    .clk (clk),
    .rst (rst),
    .ld  (rf.read),
    .d   (rd2_d),
    .q   (rf.data_r2)
  );

  always_comb begin
    op_valid_d = rf.read;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid_q <= 1'b0;
    end else begin
      op_valid_q <= op_valid_d;
    end
  end

  assign rf.op_valid = op_valid_q;

endmodule
